// File: rtl/adc_avg_pkg.sv
// Shared definitions for the ADC sample averager: default width, FSM encoding, sum sizing.
// The optional ADC_AVG_ROUND_EN macro (used in adc_sample_averager) selects rounding in stage 2.
package adc_avg_pkg;

  localparam int DATA_W_DEF = 28;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } avg_state_t;

  // N samples of DATA_W bits sum into DATA_W+LOG2_N bits without overflow
  function automatic int sum_width(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

endpackage

// File: rtl/avg_ring_buf.sv
// N x DATA_W sample history for the boxcar averager; read and write share one wrapping pointer.
module avg_ring_buf
  import adc_avg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2_N = 3
) (
  input  logic              SCLK,
  input  logic              reset,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

  logic [DATA_W-1:0] r_mem [N];
  logic [LOG2_N-1:0] r_wr_ptr;

  // Oldest sample sits at the write slot once the window is full
  assign o_rdata = r_mem[r_wr_ptr];

  // Write pointer advances per sample and wraps from N-1 back to 0
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {LOG2_N{1'b0}};
    end else if (i_we) begin
      if (r_wr_ptr == LAST_IDX) begin
        r_wr_ptr <= {LOG2_N{1'b0}};
      end else begin
        r_wr_ptr <= r_wr_ptr + LOG2_N'(1);
      end
    end
  end

  // Storage is intentionally not reset; FILL ignores stale entries
  always_ff @(posedge SCLK) begin
    if (i_we) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/adc_sample_averager.sv
// Boxcar moving average over the last 2^LOG2_N receiver samples with a valid/ready output register.
// Define ADC_AVG_ROUND_EN to round half toward +inf instead of flooring.
module adc_sample_averager
  import adc_avg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2_N = 3
) (
  input  logic                     SCLK,
  input  logic                     reset,
  input  logic                     in_tick,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     out_ready,
  input  logic                     clr_ovr,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     primed,
  output logic                     overrun
);

  localparam int SW = sum_width(DATA_W, LOG2_N);
  localparam int N  = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_CNT = LOG2_N'(N - 1);

  avg_state_t               r_state;
  logic [LOG2_N-1:0]        r_fill_cnt;
  logic signed [SW-1:0]     r_sum;
  logic                     r_pend;
  logic [DATA_W-1:0]        w_old;
  logic signed [SW-1:0]     w_in_ext;
  logic signed [SW-1:0]     w_sub;
  logic signed [SW-1:0]     w_rnd;

  avg_ring_buf #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_ring (
    .SCLK    (SCLK),
    .reset   (reset),
    .i_we    (in_tick),
    .i_wdata (in_data),
    .o_rdata (w_old)
  );

  assign w_in_ext = {{LOG2_N{in_data[DATA_W-1]}}, in_data};

  // The evicted sample only counts once the window holds N real samples
  always_comb begin
    w_sub = {SW{1'b0}};
    if (r_state == RUN) begin
      w_sub = {{LOG2_N{w_old[DATA_W-1]}}, w_old};
    end else begin
      w_sub = {SW{1'b0}};
    end
  end

`ifdef ADC_AVG_ROUND_EN
  assign w_rnd = r_sum + SW'(2 ** (LOG2_N - 1));
`else
  assign w_rnd = r_sum;
`endif

  // Fill/run FSM with registered primed flag
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      r_state    <= FILL;
      r_fill_cnt <= {LOG2_N{1'b0}};
      primed     <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (in_tick) begin
            if (r_fill_cnt == LAST_CNT) begin
              r_state <= RUN;
              primed  <= 1'b1;
            end else begin
              r_fill_cnt <= r_fill_cnt + LOG2_N'(1);
            end
          end
        end
        RUN:     r_state <= RUN;
        default: r_state <= FILL;
      endcase
    end
  end

  // Stage 1: running sum update and stage-2 request
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      r_sum  <= {SW{1'b0}};
      r_pend <= 1'b0;
    end else if (in_tick) begin
      r_sum  <= r_sum + w_in_ext - w_sub;
      r_pend <= (r_state == RUN) || (r_fill_cnt == LAST_CNT);
    end else begin
      r_pend <= 1'b0;
    end
  end

  // Stage 2: output holding register, handshake and sticky overrun (set beats clear)
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      out_data  <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (r_pend) begin
      out_data  <= DATA_W'(w_rnd >>> LOG2_N);
      out_valid <= 1'b1;
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed self-checking bench for adc_sample_averager (LOG2_N=3, DATA_W=28).
module tb_adc_sample_averager;

  logic                SCLK = 1'b0;
  logic                reset = 1'b1;
  logic                in_tick = 1'b0;
  logic signed [27:0]  in_data = 28'sd0;
  logic                out_ready = 1'b1;
  logic                clr_ovr = 1'b0;
  logic signed [27:0]  out_data;
  logic                out_valid;
  logic                primed;
  logic                overrun;

  int total = 0;
  int bad = 0;
  int exp_avg [10];

  adc_sample_averager #(
    .DATA_W (28),
    .LOG2_N (3)
  ) dut (
    .SCLK      (SCLK),
    .reset     (reset),
    .in_tick   (in_tick),
    .in_data   (in_data),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .primed    (primed),
    .overrun   (overrun)
  );

  always #5 SCLK = ~SCLK;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drives one tick; returns 1 time unit after the sampling edge
  task automatic tick(input int d);
    in_tick = 1'b1;
    in_data = 28'(d);
    @(posedge SCLK);
    #1;
    in_tick = 1'b0;
  endtask

  task automatic step();
    @(posedge SCLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_data", int'(out_data), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_primed", int'(primed), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset = 1'b0;
    step();

    // 1: fill with 80s spaced 16 cycles
    for (int i = 0; i < 7; i++) begin
      tick(80);
      step();
      chk("t1_fill_valid", int'(out_valid), 0);
      chk("t1_fill_primed", int'(primed), 0);
      repeat (14) step();
    end
    tick(80);
    chk("t1_e0_valid", int'(out_valid), 0);
    chk("t1_primed", int'(primed), 1);
    step();
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 80);
    step();
    chk("t1_drain", int'(out_valid), 0);

    // 2: zeros then -9 (floor -> -2, round -> -1)
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(0);
      step();
    end
    chk("t2_zero_data", int'(out_data), 0);
    tick(-9);
    step();
    chk("t2_valid", int'(out_valid), 1);
`ifdef ADC_AVG_ROUND_EN
    chk("t2_neg_data", int'(out_data), -1);
`else
    chk("t2_neg_data", int'(out_data), -2);
`endif

    // 3: primed with 80s, then back-to-back ticks of 160
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(80);
      step();
    end
    chk("t3_prime_data", int'(out_data), 80);
    for (int i = 0; i < 10; i++) begin
      exp_avg[i] = (i < 8) ? 90 + 10 * i : 160;
    end
    for (int i = 0; i < 10; i++) begin
      tick(160);
      if (i > 0) begin
        chk("t3_seq_data", int'(out_data), exp_avg[i-1]);
        chk("t3_seq_valid", int'(out_valid), 1);
      end
    end
    step();
    chk("t3_last_data", int'(out_data), exp_avg[9]);
    step();
    chk("t3_drain", int'(out_valid), 0);
    repeat (3) step();

    // 4: back-pressure overwrite, clear overrun, then drain
    out_ready = 1'b0;
    tick(160);
    step();
    chk("t4_first_valid", int'(out_valid), 1);
    chk("t4_first_data", int'(out_data), 160);
    chk("t4_first_ovr", int'(overrun), 0);
    tick(240);
    step();
    chk("t4_second_data", int'(out_data), 170);
    chk("t4_ovr_set", int'(overrun), 1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("t4_ovr_clr", int'(overrun), 0);
    chk("t4_hold_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    step();
    chk("t4_drain", int'(out_valid), 0);

    // 5: ready rises on the same edge as a new load
    out_ready = 1'b0;
    tick(160);
    step();
    chk("t5_first_data", int'(out_data), 170);
    tick(320);
    out_ready = 1'b1;
    step();
    chk("t5_valid", int'(out_valid), 1);
    chk("t5_data", int'(out_data), 190);
    chk("t5_ovr", int'(overrun), 0);
    step();
    chk("t5_drain", int'(out_valid), 0);

    // 6: reset after 5 fill ticks, then fresh fill of 40s
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1000);
      step();
    end
    reset = 1'b1;
    #2;
    chk("t6_rst_primed", int'(primed), 0);
    chk("t6_rst_valid", int'(out_valid), 0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      tick(40);
      step();
      chk("t6_fill_valid", int'(out_valid), 0);
      step();
    end
    tick(40);
    chk("t6_e0_valid", int'(out_valid), 0);
    step();
    chk("t6_valid", int'(out_valid), 1);
    chk("t6_data", int'(out_data), 40);
    chk("t6_primed", int'(primed), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
